// File: rtl/io_bank_pkg.sv
// Shared constants and types for the configurable pad I/O bank.
package io_bank_pkg;

  // Mode bits per channel
  localparam int unsigned CFG_W = 3;

  // Bit positions inside one channel's mode field
  localparam int unsigned MODE_DIR = 0;
  localparam int unsigned MODE_REG = 1;
  localparam int unsigned MODE_INV = 2;

  // Serial configuration load sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    APPLY = 2'd2
  } load_state_e;

endpackage

// File: rtl/io_chan.sv
// One pad channel: input synchroniser, output register, direction and
// polarity muxing selected by a 3-bit mode.
module io_chan
  import io_bank_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CFG_W-1:0] mode,
  input  logic             pad_in,
  input  logic             core_in,
  output logic             pad_out,
  output logic             pad_oe,
  output logic             core_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   oreg_q;
  logic                   dir;
  logic                   reg_en;
  logic                   inv;
  logic                   in_val;
  logic                   out_val;

  assign dir    = mode[MODE_DIR];
  assign reg_en = mode[MODE_REG];
  assign inv    = mode[MODE_INV];

  // Input synchroniser; runs in every mode so a mode change never flushes it
  generate
    if (SYNC_STAGES == 1) begin : g_sync1
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= pad_in;
      end
    end else begin : g_syncn
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
      end
    end
  endgenerate

  // Output register, also free-running
  always_ff @(posedge clk) begin
    if (rst) oreg_q <= 1'b0;
    else     oreg_q <= core_in;
  end

  assign in_val  = reg_en ? sync_q[SYNC_STAGES-1] : pad_in;
  assign out_val = reg_en ? oreg_q : core_in;

  // Direction steering: the unused side of the channel is held at 0
  always_comb begin
    pad_out  = 1'b0;
    pad_oe   = 1'b0;
    core_out = 1'b0;
    if (dir) begin
      pad_out = out_val ^ inv;
      pad_oe  = 1'b1;
    end else begin
      core_out = in_val ^ inv;
    end
  end

endmodule

// File: rtl/io_bank_if.sv
// Runtime-configurable pad I/O bank. Modes are shifted in serially into a
// shadow register and copied to the active register in a single cycle so a
// full mode set switches atomically.
module io_bank_if
  import io_bank_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] pad_in,
  output logic [NUM_CH-1:0] pad_out,
  output logic [NUM_CH-1:0] pad_oe,
  input  logic [NUM_CH-1:0] core_in,
  output logic [NUM_CH-1:0] core_out,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_data,
  output logic              cfg_ready,
  output logic              cfg_busy,
  output logic              cfg_done
);

  localparam int unsigned TOTAL = NUM_CH * CFG_W;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  load_state_e      state;
  logic [CNT_W-1:0] count;
  logic [TOTAL-1:0] shadow;
  logic [TOTAL-1:0] active;

  // Load sequencer: shift into shadow, then one APPLY cycle commits it
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      shadow   <= '0;
      active   <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE, SHIFT: begin
          if (cfg_start) begin
            // Restart wins over a same-cycle bit, which is dropped
            count <= '0;
            state <= IDLE;
          end else if (cfg_valid) begin
            shadow <= {shadow[TOTAL-2:0], cfg_data};
            count  <= count + CNT_W'(1);
            state  <= (count == CNT_W'(TOTAL - 1)) ? APPLY : SHIFT;
          end
        end
        APPLY: begin
          // cfg_start and cfg_valid are deliberately ignored here
          active   <= shadow;
          cfg_done <= 1'b1;
          count    <= '0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Handshake status decoded from the state register
  assign cfg_ready = (state != APPLY);
  assign cfg_busy  = (state != IDLE);

  // Per-channel datapaths driven by the active mode field
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      io_chan #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .mode     (active[CFG_W*i +: CFG_W]),
        .pad_in   (pad_in[i]),
        .core_in  (core_in[i]),
        .pad_out  (pad_out[i]),
        .pad_oe   (pad_oe[i]),
        .core_out (core_out[i])
      );
    end
  endgenerate

endmodule
